// File: rtl/dram_pkg.sv
// Shared DRAM sample-path definitions: widths, chunk word layout and the
// writer FSM encoding. The read path consumes the same chunk_word_t layout.
package dram_pkg;

    localparam int ADDR_W        = 24;
    localparam int SAMPLE_W      = 16;
    localparam int CHUNK_SAMPLES = 8;
    localparam int DATA_W        = SAMPLE_W * CHUNK_SAMPLES;
    localparam int CHUNK_W       = ADDR_W + DATA_W;
    localparam int IDX_W         = $clog2(CHUNK_SAMPLES);

    // One DRAM chunk word as carried on the AXI stream: address in the MSBs.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } chunk_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SEND = 2'd2
    } wr_state_t;

endpackage

// File: rtl/dram_writer_sample_stacker.sv
// sample_stacker: packs consecutive samples into one chunk-wide register.
// Sample k of a chunk lands in lane k (sample 0 in the LSBs). Also remembers
// whether the most recently accepted sample carried tlast.
module sample_stacker
    import dram_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                accept,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                last,
    output logic [DATA_W-1:0]   data,
    output logic [IDX_W-1:0]    index,
    output logic                last_seen
);

    // Lane write, fill index and tlast capture; clear wins over accept so a
    // dropped tail leaves the register zeroed for the next chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data      <= '0;
            index     <= '0;
            last_seen <= 1'b0;
        end else if (clear) begin
            data      <= '0;
            index     <= '0;
            last_seen <= 1'b0;
        end else if (accept) begin
            for (int k = 0; k < CHUNK_SAMPLES; k++) begin
                if (index == IDX_W'(k)) begin
                    data[k*SAMPLE_W +: SAMPLE_W] <= sample;
                end
            end
            index     <= index + IDX_W'(1);
            last_seen <= last;
        end
    end

endmodule

// File: rtl/dram_writer.sv
// dram_writer: packs a 16-bit sample stream into 128-bit chunks and emits
// {addr, data} words toward the DRAM write FIFO during sample load.
// Build option DRAM_WRITER_LAST_FLUSH_EN: when defined, a tlast before the
// chunk is full emits a zero-padded partial chunk; otherwise the partial
// samples are dropped and done pulses on the following cycle.
module dram_writer
    import dram_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                sample_axis_tvalid,
    output logic                sample_axis_tready,
    input  logic [SAMPLE_W-1:0] sample_axis_tdata,
    input  logic                sample_axis_tlast,
    output logic                chunk_axis_tvalid,
    input  logic                chunk_axis_tready,
    output logic [CHUNK_W-1:0]  chunk_axis_tdata,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   next_addr
);

    wr_state_t          state;
    wr_state_t          state_nxt;
    logic               accept;
    logic               clear;
    logic               load_addr;
    logic               inc_addr;
    logic               send_done;
    logic               drop_set;
    logic               drop_done;
    logic [DATA_W-1:0]  data;
    logic [IDX_W-1:0]   index;
    logic               last_seen;
    chunk_word_t        word;

    assign accept = sample_axis_tvalid && sample_axis_tready;

    sample_stacker u_stacker (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .accept    (accept),
        .sample    (sample_axis_tdata),
        .last      (sample_axis_tlast),
        .data      (data),
        .index     (index),
        .last_seen (last_seen)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; every output defaults to inactive.
    always_comb begin
        state_nxt          = state;
        sample_axis_tready = 1'b0;
        chunk_axis_tvalid  = 1'b0;
        clear              = 1'b0;
        load_addr          = 1'b0;
        inc_addr           = 1'b0;
        send_done          = 1'b0;
        drop_set           = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    load_addr = 1'b1;
                    clear     = 1'b1;
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                sample_axis_tready = 1'b1;
                if (accept) begin
                    if (index == IDX_W'(CHUNK_SAMPLES - 1)) begin
                        state_nxt = ST_SEND;
                    end else if (sample_axis_tlast) begin
`ifdef DRAM_WRITER_LAST_FLUSH_EN
                        state_nxt = ST_SEND;
`else
                        clear     = 1'b1;
                        drop_set  = 1'b1;
                        state_nxt = ST_IDLE;
`endif
                    end
                end
            end
            ST_SEND: begin
                chunk_axis_tvalid = 1'b1;
                if (chunk_axis_tready) begin
                    clear    = 1'b1;
                    inc_addr = 1'b1;
                    if (last_seen) begin
                        send_done = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_FILL;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Chunk address: loaded on start, advanced once per accepted chunk word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_addr <= '0;
        end else if (load_addr) begin
            next_addr <= base_addr;
        end else if (inc_addr) begin
            next_addr <= next_addr + ADDR_W'(1);
        end
    end

    // A dropped tail reports done one cycle after its tlast sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_done <= 1'b0;
        end else begin
            drop_done <= drop_set;
        end
    end

    assign word.addr        = next_addr;
    assign word.data        = data;
    assign chunk_axis_tdata = word;
    assign busy             = (state != ST_IDLE);
    assign done             = send_done || drop_done;

endmodule

// File: tb/tb_dram_writer.sv
// Scoreboard bench for dram_writer: stimulus pushes expected chunk words,
// a negedge monitor pops and compares on every chunk handshake.
module tb_dram_writer;
    import dram_pkg::*;

`ifdef DRAM_WRITER_LAST_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic                sample_tvalid = 1'b0;
    logic                sample_tready;
    logic [SAMPLE_W-1:0] sample_tdata = '0;
    logic                sample_tlast = 1'b0;
    logic                chunk_tvalid;
    logic                chunk_tready = 1'b1;
    logic [CHUNK_W-1:0]  chunk_tdata;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   next_addr;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    bit bp_en = 1'b0;

    logic [CHUNK_W-1:0] exp_q[$];
    logic [CHUNK_W-1:0] last_word = '0;
    logic [CHUNK_W-1:0] held_data = '0;
    bit                 held = 1'b0;

    logic [DATA_W-1:0]  m_data;
    int                 m_idx;
    logic [ADDR_W-1:0]  m_addr;

    dram_writer dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .base_addr          (base_addr),
        .sample_axis_tvalid (sample_tvalid),
        .sample_axis_tready (sample_tready),
        .sample_axis_tdata  (sample_tdata),
        .sample_axis_tlast  (sample_tlast),
        .chunk_axis_tvalid  (chunk_tvalid),
        .chunk_axis_tready  (chunk_tready),
        .chunk_axis_tdata   (chunk_tdata),
        .busy               (busy),
        .done               (done),
        .next_addr          (next_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [CHUNK_W-1:0] act, input logic [CHUNK_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: chunk handshakes, tdata stability under stall, done pulses.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (chunk_tvalid) begin
                if (held) check("tdata_stable", chunk_tdata, held_data);
                if (chunk_tready) begin
                    held = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL chunk_unexpected: actual=%h required=none", chunk_tdata);
                    end else begin
                        logic [CHUNK_W-1:0] e;
                        e = exp_q.pop_front();
                        if (chunk_tdata !== e) begin
                            failures++;
                            $display("FAIL chunk_word: actual=%h required=%h", chunk_tdata, e);
                        end
                    end
                    last_word = chunk_tdata;
                end else begin
                    held = 1'b1;
                    held_data = chunk_tdata;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // Random output backpressure while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bp_en) chunk_tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic model_start(input logic [ADDR_W-1:0] b);
        m_addr = b;
        m_data = '0;
        m_idx  = 0;
    endtask

    task automatic model_accept(input logic [SAMPLE_W-1:0] v, input logic l);
        m_data[m_idx*SAMPLE_W +: SAMPLE_W] = v;
        m_idx++;
        if (m_idx == CHUNK_SAMPLES || (l && FLUSH)) begin
            exp_q.push_back({m_addr, m_data});
            m_addr = m_addr + 24'd1;
            m_data = '0;
            m_idx  = 0;
        end else if (l) begin
            m_data = '0;
            m_idx  = 0;
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input bit expect_taken);
        start = 1'b1;
        base_addr = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_taken) model_start(b);
    endtask

    task automatic push_sample(input logic [SAMPLE_W-1:0] v, input logic l);
        int waited;
        bit ok;
        waited = 0;
        ok = 1'b0;
        sample_tvalid = 1'b1;
        sample_tdata  = v;
        sample_tlast  = l;
        while (!ok && waited < 100) begin
            @(negedge clk);
            if (sample_tready) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL sample_accept: actual=tready_low required=accepted value=%h", v);
        end
        @(posedge clk);
        #1;
        sample_tvalid = 1'b0;
        sample_tlast  = 1'b0;
        if (ok) model_accept(v, l);
    endtask

    task automatic push_run(input logic [SAMPLE_W-1:0] first, input int n, input bit tail_last);
        for (int i = 0; i < n; i++) begin
            push_sample(first + SAMPLE_W'(i), tail_last && (i == n - 1));
        end
    endtask

    task automatic wait_done(input string name, input int exp_done_total);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, CHUNK_W'(seen), CHUNK_W'(1));
        @(negedge clk);
        check({name, "_done_count"}, CHUNK_W'(done_cnt), CHUNK_W'(exp_done_total));
        check({name, "_queue_empty"}, CHUNK_W'(exp_q.size()), CHUNK_W'(0));
        check({name, "_busy_low"}, CHUNK_W'(busy), CHUNK_W'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", CHUNK_W'(chunk_tvalid), CHUNK_W'(0));
        check("rst_busy", CHUNK_W'(busy), CHUNK_W'(0));
        check("rst_done", CHUNK_W'(done), CHUNK_W'(0));
        check("rst_tready", CHUNK_W'(sample_tready), CHUNK_W'(0));
        check("rst_next_addr", CHUNK_W'(next_addr), CHUNK_W'(0));
        check("rst_tdata", chunk_tdata, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Samples offered in IDLE are not accepted
        sample_tvalid = 1'b1;
        @(negedge clk);
        check("idle_tready", CHUNK_W'(sample_tready), CHUNK_W'(0));
        @(posedge clk);
        #1;
        sample_tvalid = 1'b0;

        // Full chunk
        do_start(24'h000100, 1'b1);
        check("busy_after_start", CHUNK_W'(busy), CHUNK_W'(1));
        push_run(16'h0001, 8, 1'b1);
        wait_done("full", 1);
        check("full_word_literal", last_word,
              {24'h000100, 128'h0008_0007_0006_0005_0004_0003_0002_0001});
        check("full_next_addr", CHUNK_W'(next_addr), CHUNK_W'(24'h000101));

        // Backpressure, 24 samples
        bp_en = 1'b1;
        do_start(24'h000200, 1'b1);
        push_run(16'h1000, 24, 1'b1);
        wait_done("bp", 2);
        bp_en = 1'b0;
        chunk_tready = 1'b1;
        check("bp_last_word", last_word,
              {24'h000202, 128'h1017_1016_1015_1014_1013_1012_1011_1010});
        check("bp_next_addr", CHUNK_W'(next_addr), CHUNK_W'(24'h000203));

        // Address wrap
        do_start(24'hFFFFFF, 1'b1);
        push_run(16'h2000, 16, 1'b1);
        wait_done("wrap", 3);
        check("wrap_last_word", last_word,
              {24'h000000, 128'h200F_200E_200D_200C_200B_200A_2009_2008});
        check("wrap_next_addr", CHUNK_W'(next_addr), CHUNK_W'(24'h000001));

        // Partial tail of 11 samples
        do_start(24'h000300, 1'b1);
        push_run(16'h0001, 11, 1'b1);
        wait_done("tail", 4);
        if (FLUSH) begin
            check("tail_last_word", last_word, {24'h000301, 80'h0, 48'h000B_000A_0009});
            check("tail_next_addr", CHUNK_W'(next_addr), CHUNK_W'(24'h000302));
        end else begin
            check("tail_last_word", last_word,
                  {24'h000300, 128'h0008_0007_0006_0005_0004_0003_0002_0001});
            check("tail_next_addr", CHUNK_W'(next_addr), CHUNK_W'(24'h000301));
        end

        // Reset mid-fill after 5 samples
        do_start(24'h000400, 1'b1);
        push_run(16'h3000, 5, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tvalid", CHUNK_W'(chunk_tvalid), CHUNK_W'(0));
        check("midrst_busy", CHUNK_W'(busy), CHUNK_W'(0));
        check("midrst_done", CHUNK_W'(done), CHUNK_W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_start(24'h000500, 1'b1);
        push_run(16'h4000, 8, 1'b1);
        wait_done("after_rst", 5);
        check("after_rst_word", last_word,
              {24'h000500, 128'h4007_4006_4005_4004_4003_4002_4001_4000});

        // start while busy is ignored
        do_start(24'h000600, 1'b1);
        push_run(16'h5000, 4, 1'b0);
        do_start(24'h000777, 1'b0);
        push_run(16'h5004, 12, 1'b1);
        wait_done("busy_start", 6);
        check("busy_start_word", last_word,
              {24'h000601, 128'h500F_500E_500D_500C_500B_500A_5009_5008});
        check("busy_start_next_addr", CHUNK_W'(next_addr), CHUNK_W'(24'h000602));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dram_writer.md
Name: dram_writer

Overview:
- Write-side counterpart of the DRAM sample-read path; used during sample load.
- Accepts a stream of 16-bit samples for one instrument and packs 8 samples into a 128-bit chunk.
- Tags each chunk with a 24-bit chunk address starting at a programmed base.
- Emits {addr, data} as a 152-bit AXI-stream word toward the DRAM write clockdomain FIFO, in the same word format the read path consumes.

Parameters:
- ADDR_W, 24, chunk address width; output tdata[151:128].
- SAMPLE_W, 16, sample width.
- CHUNK_SAMPLES, 8, samples per chunk; data width is SAMPLE_W*CHUNK_SAMPLES = 128.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; latches base_addr and begins a transfer.
- base_addr  input  24  first chunk address of the transfer.
- sample_axis_tvalid  input  1  sample valid.
- sample_axis_tready  output  1  sample accepted when high with tvalid.
- sample_axis_tdata  input  16  sample value.
- sample_axis_tlast  input  1  marks the final sample of the instrument.
- chunk_axis_tvalid  output  1  chunk word valid.
- chunk_axis_tready  input  1  FIFO ready.
- chunk_axis_tdata  output  152  {addr[23:0], data[127:0]}.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse at the end of the transfer.
- next_addr  output  24  address the next chunk would use; after done, this is the next instrument's addr_starts entry.

Behaviour:
- Reset values: all outputs 0; state IDLE; fill index 0; data register 0.
- States:
  - IDLE: sample_axis_tready=0. On start, next_addr<=base_addr, index<=0, go to FILL.
  - FILL: sample_axis_tready=1. Each accepted sample k is written to data[16k+15:16k]; sample 0 occupies the LSBs. When index==7 is accepted, or the flush condition below is met, go to SEND.
  - SEND: sample_axis_tready=0. chunk_axis_tvalid=1 with tdata={next_addr, data}; tdata is held stable while tvalid && !tready. On handshake: next_addr<=next_addr+1, data<=0, index<=0. Then go to FILL, or go to IDLE if the chunk ended in tlast (done pulses in the handshake cycle).
- Latency: chunk_axis_tvalid rises the cycle after the 8th sample handshake. Peak throughput is 8 samples per 9 cycles.
- Address: next_addr increments by 1 per chunk and wraps modulo 2^24 (0xFFFFFF -> 0x000000) without error.
- tlast on sample index 7: normal SEND, then IDLE plus done.
- start while busy: ignored. sample tvalid in IDLE: not accepted (tready=0).
- chunk_axis_tready held low: writer stalls in SEND with no data loss.
- Reset mid-transfer: immediate return to IDLE; the partial chunk is discarded; no done pulse.

Optional Feature:
- Macro: DRAM_WRITER_LAST_FLUSH_EN.
- Defined: tlast at index<7 moves to SEND with a zero-padded partial chunk, then IDLE plus done. next_addr includes that chunk.
- Undefined: tlast at index<7 drops the partial samples and does not emit them. Go to IDLE, pulse done the next cycle, next_addr unchanged.

Decomposition:
- Shared package dram_pkg holds:
  - constants ADDR_W, SAMPLE_W, CHUNK_SAMPLES, CHUNK_W=152;
  - typedef chunk_word_t as a packed struct {addr, data}.
- The read path shares dram_pkg.
- One sub-module, sample_stacker: performs the 16-to-128 packing with index counter and tlast capture. dram_writer adds the address and FSM wrapper.

Test Plan:
- Full chunk: start with base=0x000100, send samples 0x0001..0x0008, tlast on the 8th -> one word 0x000100_0008000700060005000400030002_0001, done pulse, next_addr=0x000101.
- Backpressure: 24 samples with chunk_axis_tready toggling randomly -> 3 words at addrs base..base+2; tdata stable while stalled; no sample lost or duplicated.
- Wrap: base=0xFFFFFF, 16 samples -> chunk addrs 0xFFFFFF then 0x000000; next_addr=0x000001.
- Partial tail with DRAM_WRITER_LAST_FLUSH_EN: 11 samples -> 2 words, the second holding samples 9..11 in the low 48 bits and zeros above, done pulse. Without the macro -> 1 word, done pulse, next_addr=base+1.
- Reset mid-fill after 5 samples -> tvalid/busy low next cycle, no chunk emitted; a new start then yields a clean chunk at the new base.
- start asserted while busy with a different base -> ignored; addresses continue from the original base.
